// File: rtl/pool_ctrl.sv
// pool_ctrl: 2x2/stride-2 signed int8 max-pool sequencer, IFM BRAM -> OFM BRAM, 4 channels per word.
// Optional fused ReLU on the written word when POOL_RELU_EN is defined.
module pool_ctrl #(
    parameter int unsigned IFM_AW = 18,
    parameter int unsigned OFM_AW = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              pool_start,
    input  logic [5:0]        flen,
    input  logic [8:0]        in_channel,
    output logic              pool_done,
    output logic [31:0]       clk_counter,
    output logic              busy,
    output logic              ifm_en,
    output logic [IFM_AW-1:0] ifm_addr,
    input  logic [31:0]       ifm_rdata,
    output logic              ofm_we,
    output logic [OFM_AW-1:0] ofm_addr,
    output logic [31:0]       ofm_wdata
);
    localparam int unsigned GW = 8;
    localparam int unsigned FW = 5;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_RD0, S_RD1, S_RD2, S_RD3, S_DRAIN, S_WR, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              start_prev_q;
    logic              start_edge;
    logic              n_zero;
    logic              last_win;
    logic [5:0]        flen_q, flen_d;
    logic [FW-1:0]     fo_q, fo_d;
    logic [GW-1:0]     grp_q, grp_d;
    logic [GW-1:0]     g_q, g_d;
    logic [FW-1:0]     r_q, r_d, c_q, c_d;
    logic [31:0]       max_q, max_d;
    logic              pool_done_q, pool_done_d;
    logic [31:0]       clk_counter_q, clk_counter_d;
    logic              busy_q, busy_d;
    logic              ifm_en_q, ifm_en_d;
    logic [IFM_AW-1:0] ifm_addr_q, ifm_addr_d;
    logic              ofm_we_q, ofm_we_d;
    logic [OFM_AW-1:0] ofm_addr_q, ofm_addr_d;
    logic [31:0]       ofm_wdata_q, ofm_wdata_d;
    logic              dy, dx;
    logic [5:0]        row, col;

    function automatic logic [31:0] lane_max(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = ($signed(a[8*i +: 8]) > $signed(b[8*i +: 8])) ? a[8*i +: 8] : b[8*i +: 8];
        end
        return res;
    endfunction

`ifdef POOL_RELU_EN
    function automatic logic [31:0] out_word(input logic [31:0] w);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = w[8*i+7] ? 8'h00 : w[8*i +: 8];
        end
        return res;
    endfunction
`else
    function automatic logic [31:0] out_word(input logic [31:0] w);
        return w;
    endfunction
`endif

    assign start_edge = pool_start && !start_prev_q && (state_q == S_IDLE);
    assign n_zero     = (flen[5:1] == 5'd0) || (in_channel == 9'd0);
    assign last_win   = (g_q == grp_q - GW'(1)) && (r_q == fo_q - FW'(1)) && (c_q == fo_q - FW'(1));

    // State and datapath registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= S_IDLE;
            start_prev_q  <= 1'b0;
            flen_q        <= '0;
            fo_q          <= '0;
            grp_q         <= '0;
            g_q           <= '0;
            r_q           <= '0;
            c_q           <= '0;
            max_q         <= '0;
            pool_done_q   <= 1'b0;
            clk_counter_q <= '0;
            busy_q        <= 1'b0;
            ifm_en_q      <= 1'b0;
            ifm_addr_q    <= '0;
            ofm_we_q      <= 1'b0;
            ofm_addr_q    <= '0;
            ofm_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            start_prev_q  <= pool_start;
            flen_q        <= flen_d;
            fo_q          <= fo_d;
            grp_q         <= grp_d;
            g_q           <= g_d;
            r_q           <= r_d;
            c_q           <= c_d;
            max_q         <= max_d;
            pool_done_q   <= pool_done_d;
            clk_counter_q <= clk_counter_d;
            busy_q        <= busy_d;
            ifm_en_q      <= ifm_en_d;
            ifm_addr_q    <= ifm_addr_d;
            ofm_we_q      <= ofm_we_d;
            ofm_addr_q    <= ofm_addr_d;
            ofm_wdata_q   <= ofm_wdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_edge) state_d = S_LOAD;
            S_LOAD:  state_d = n_zero ? S_DONE : S_RD0;
            S_RD0:   state_d = S_RD1;
            S_RD1:   state_d = S_RD2;
            S_RD2:   state_d = S_RD3;
            S_RD3:   state_d = S_DRAIN;
            S_DRAIN: state_d = S_WR;
            S_WR:    state_d = last_win ? S_DONE : S_RD0;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counters, lane reduction and registered outputs aligned with the next state
    always_comb begin
        flen_d        = flen_q;
        fo_d          = fo_q;
        grp_d         = grp_q;
        g_d           = g_q;
        r_d           = r_q;
        c_d           = c_q;
        max_d         = max_q;
        pool_done_d   = pool_done_q;
        clk_counter_d = clk_counter_q;
        ifm_addr_d    = ifm_addr_q;
        ofm_addr_d    = ofm_addr_q;
        ofm_wdata_d   = ofm_wdata_q;
        dy            = 1'b0;
        dx            = 1'b0;

        case (state_q)
            S_LOAD: begin
                flen_d = flen;
                fo_d   = flen[5:1];
                grp_d  = GW'((10'(in_channel) + 10'd3) >> 2);
                g_d    = '0;
                r_d    = '0;
                c_d    = '0;
            end
            S_RD1:                 max_d = ifm_rdata;
            S_RD2, S_RD3, S_DRAIN: max_d = lane_max(max_q, ifm_rdata);
            S_WR: begin
                if (c_q == fo_q - FW'(1)) begin
                    c_d = '0;
                    if (r_q == fo_q - FW'(1)) begin
                        r_d = '0;
                        g_d = g_q + GW'(1);
                    end else begin
                        r_d = r_q + FW'(1);
                    end
                end else begin
                    c_d = c_q + FW'(1);
                end
            end
            default: ;
        endcase

        if (start_edge) begin
            clk_counter_d = '0;
            pool_done_d   = 1'b0;
        end else if (state_q != S_IDLE && clk_counter_q != 32'hFFFF_FFFF) begin
            clk_counter_d = clk_counter_q + 32'd1;
        end
        if (state_d == S_DONE) pool_done_d = 1'b1;

        case (state_d)
            S_RD1: dx = 1'b1;
            S_RD2: dy = 1'b1;
            S_RD3: begin dy = 1'b1; dx = 1'b1; end
            default: ;
        endcase
        row = {r_d, 1'b0} + 6'(dy);
        col = {c_d, 1'b0} + 6'(dx);

        busy_d   = (state_d != S_IDLE);
        ifm_en_d = (state_d inside {S_RD0, S_RD1, S_RD2, S_RD3});
        ofm_we_d = (state_d == S_WR);
        if (ifm_en_d) begin
            ifm_addr_d = IFM_AW'(32'(g_d) * 32'(flen_d) * 32'(flen_d) + 32'(row) * 32'(flen_d) + 32'(col));
        end
        if (ofm_we_d) begin
            ofm_addr_d  = OFM_AW'(32'(g_d) * 32'(fo_d) * 32'(fo_d) + 32'(r_d) * 32'(fo_d) + 32'(c_d));
            ofm_wdata_d = out_word(max_d);
        end
    end

    assign pool_done   = pool_done_q;
    assign clk_counter = clk_counter_q;
    assign busy        = busy_q;
    assign ifm_en      = ifm_en_q;
    assign ifm_addr    = ifm_addr_q;
    assign ofm_we      = ofm_we_q;
    assign ofm_addr    = ofm_addr_q;
    assign ofm_wdata   = ofm_wdata_q;
endmodule

// File: tb/tb_pool_ctrl.sv
// Self-checking bench for pool_ctrl: vector table, directed corner sequences and random runs vs a window-level model.
module tb_pool_ctrl;
    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        pool_start;
    logic [5:0]  flen;
    logic [8:0]  in_channel;
    logic        pool_done;
    logic [31:0] clk_counter;
    logic        busy;
    logic        ifm_en;
    logic [17:0] ifm_addr;
    logic [31:0] ifm_rdata;
    logic        ofm_we;
    logic [15:0] ofm_addr;
    logic [31:0] ofm_wdata;

    pool_ctrl #(.IFM_AW(18), .OFM_AW(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .pool_start(pool_start), .flen(flen),
        .in_channel(in_channel), .pool_done(pool_done), .clk_counter(clk_counter),
        .busy(busy), .ifm_en(ifm_en), .ifm_addr(ifm_addr), .ifm_rdata(ifm_rdata),
        .ofm_we(ofm_we), .ofm_addr(ofm_addr), .ofm_wdata(ofm_wdata)
    );

    always #5 PCLK = ~PCLK;

`ifdef POOL_RELU_EN
    localparam logic [31:0] SPECIAL_EXP = 32'h0000_007F;
`else
    localparam logic [31:0] SPECIAL_EXP = 32'h0000_F07F;
`endif

    logic [31:0] mem [0:1023];
    int          rd_q[$];
    int          wa_q[$];
    logic [31:0] wd_q[$];
    int          exp_rd[$];
    int          exp_wa[$];
    logic [31:0] exp_wd[$];
    int          overlap = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    // IFM BRAM with one-cycle read latency, plus OFM write / read-address capture
    always @(posedge PCLK) begin
        if (ifm_en) begin
            rd_q.push_back(int'(ifm_addr));
            ifm_rdata <= mem[ifm_addr[9:0]];
        end
        if (ofm_we) begin
            wa_q.push_back(int'(ofm_addr));
            wd_q.push_back(ofm_wdata);
        end
        if (ifm_en && ofm_we) overlap++;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int a = 0; a < 1024; a++) begin
            case (mode)
                0:       mem[a] = 32'(a);
                1:       mem[a] = 32'h0;
                default: mem[a] = $urandom;
            endcase
        end
        if (mode == 1) begin
            mem[0] = 32'h0000_F080;
            mem[1] = 32'h0000_F0FF;
            mem[2] = 32'h0000_F001;
            mem[3] = 32'h0000_F07F;
        end
    endtask

    // Window-level reference: per output pixel, signed max of the four covering pixels in each lane
    task automatic build_model(input int fl, input int ch);
        int f, g_n, a;
        int m [4];
        byte b;
        logic [31:0] w;
        f   = fl / 2;
        g_n = (ch + 3) / 4;
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        for (int g = 0; g < g_n; g++)
            for (int r = 0; r < f; r++)
                for (int c = 0; c < f; c++) begin
                    for (int l = 0; l < 4; l++) m[l] = -128;
                    for (int k = 0; k < 4; k++) begin
                        a = g*fl*fl + (2*r + k/2)*fl + 2*c + k%2;
                        exp_rd.push_back(a);
                        for (int l = 0; l < 4; l++) begin
                            w = mem[a];
                            b = w[8*l +: 8];
                            if (int'(b) > m[l]) m[l] = int'(b);
                        end
                    end
                    for (int l = 0; l < 4; l++) begin
`ifdef POOL_RELU_EN
                        if (m[l] < 0) m[l] = 0;
`endif
                        w[8*l +: 8] = 8'(m[l]);
                    end
                    exp_wa.push_back(g*f*f + r*f + c);
                    exp_wd.push_back(w);
                end
    endtask

    task automatic clear_capture();
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        overlap = 0;
    endtask

    task automatic start_run(input int fl, input int ch);
        @(negedge PCLK);
        pool_start = 1'b0;
        flen       = 6'(fl);
        in_channel = 9'(ch);
        clear_capture();
        @(negedge PCLK);
        pool_start = 1'b1;
    endtask

    task automatic wait_done(input string nm, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge PCLK);
            if (pool_done && !busy) seen = 1'b1;
        end
        if (!seen) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic check_results(input string nm);
        chk({nm, "_cycles"}, clk_counter, 6*exp_wa.size() + 2);
        chk({nm, "_done"}, pool_done, 1);
        chk({nm, "_nwr"}, wa_q.size(), exp_wa.size());
        chk({nm, "_nrd"}, rd_q.size(), exp_rd.size());
        chk({nm, "_overlap"}, overlap, 0);
        for (int i = 0; i < wa_q.size() && i < exp_wa.size(); i++) begin
            chk($sformatf("%s_waddr%0d", nm, i), wa_q[i], exp_wa[i]);
            chk($sformatf("%s_wdata%0d", nm, i), wd_q[i], exp_wd[i]);
        end
        for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++)
            chk($sformatf("%s_raddr%0d", nm, i), rd_q[i], exp_rd[i]);
    endtask

    task automatic run_case(input string nm, input int fl, input int ch);
        build_model(fl, ch);
        start_run(fl, ch);
        wait_done(nm, 6*exp_wa.size() + 30);
        check_results(nm);
    endtask

    typedef struct {
        int          fl;
        int          ch;
        int          mode;
        int          exp_cyc;
        bit          chk_first;
        logic [31:0] first_wd;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int k;
        tbl[0] = '{4, 4, 0, 26, 1'b1, 32'h5};
        tbl[1] = '{2, 4, 1, 8, 1'b1, SPECIAL_EXP};
        tbl[2] = '{5, 8, 2, 50, 1'b0, 32'h0};
        tbl[3] = '{1, 4, 2, 2, 1'b0, 32'h0};
        tbl[4] = '{4, 0, 2, 2, 1'b0, 32'h0};
        tbl[5] = '{7, 3, 2, 56, 1'b0, 32'h0};
        tbl[6] = '{6, 13, 2, 218, 1'b0, 32'h0};
        tbl[7] = '{3, 5, 2, 14, 1'b0, 32'h0};

        PRESET = 1'b1; pool_start = 1'b0; flen = '0; in_channel = '0;
        repeat (3) @(negedge PCLK);
        chk("rst_done", pool_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", clk_counter, 0);
        chk("rst_ifm_en", ifm_en, 0);
        chk("rst_ofm_we", ofm_we, 0);
        chk("rst_ofm_wdata", ofm_wdata, 0);
        PRESET = 1'b0;

        for (int i = 0; i < 8; i++) begin
            fill(tbl[i].mode);
            run_case($sformatf("vec%0d", i), tbl[i].fl, tbl[i].ch);
            chk($sformatf("vec%0d_cnt_const", i), clk_counter, tbl[i].exp_cyc);
            if (tbl[i].chk_first)
                chk($sformatf("vec%0d_first", i), wd_q.size() > 0 ? longint'(wd_q[0]) : -1, tbl[i].first_wd);
            if (tbl[i].fl == 5) begin
                chk("f5_g1_first_rd", rd_q.size() > 16 ? rd_q[16] : -1, 25);
                chk("f5_wa4", wa_q.size() > 4 ? wa_q[4] : -1, 4);
                chk("f5_wa7", wa_q.size() > 7 ? wa_q[7] : -1, 7);
            end
        end

        // Level held through DONE and a mid-run toggle must not restart
        fill(0);
        build_model(4, 4);
        start_run(4, 4);
        repeat (10) @(negedge PCLK);
        pool_start = 1'b0;
        @(negedge PCLK);
        pool_start = 1'b1;
        wait_done("hold", 60);
        check_results("hold");
        repeat (5) @(negedge PCLK);
        chk("hold_busy", busy, 0);
        chk("hold_done", pool_done, 1);
        chk("hold_cnt", clk_counter, 26);
        @(negedge PCLK);
        pool_start = 1'b0;
        clear_capture();
        @(negedge PCLK);
        pool_start = 1'b1;
        @(negedge PCLK);
        chk("restart_done_clr", pool_done, 0);
        chk("restart_cnt_clr", clk_counter, 0);
        chk("restart_busy", busy, 1);
        wait_done("restart", 60);
        check_results("restart");

        // Reset during RD2 of window 1 aborts the run
        fill(2);
        start_run(4, 8);
        k = 0;
        for (int t = 0; t < 100 && k < 7; t++) begin
            @(negedge PCLK);
            if (ifm_en) k++;
        end
        chk("abort_reached_rd2", k, 7);
        PRESET = 1'b1;
        pool_start = 1'b0;
        @(negedge PCLK);
        chk("abort_busy", busy, 0);
        chk("abort_ifm_en", ifm_en, 0);
        chk("abort_ifm_addr", ifm_addr, 0);
        chk("abort_ofm_we", ofm_we, 0);
        chk("abort_ofm_addr", ofm_addr, 0);
        chk("abort_wdata", ofm_wdata, 0);
        chk("abort_cnt", clk_counter, 0);
        chk("abort_done", pool_done, 0);
        PRESET = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("abort_nwr", wa_q.size(), 1);
        run_case("post_abort", 4, 8);
        chk("post_abort_wa0", wa_q.size() > 0 ? wa_q[0] : -1, 0);

        for (int i = 0; i < 6; i++) begin
            fill(2);
            run_case($sformatf("rand%0d", i), $urandom_range(0, 10), $urandom_range(0, 20));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pool_ctrl.md
Name: pool_ctrl

Overview:
Sequencer for the 2x2/stride-2 max-pool datapath. Driven by the APB pool register bank (pool_start, flen, in_channel); returns pool_done and clk_counter to it. Walks the input feature map (IFM) BRAM window by window and reduces each window with a signed int8 max, 4 channels per 32-bit word. Writes one pooled word per window to the output feature map (OFM) BRAM.

Parameters:
IFM_AW, 18, IFM BRAM address width (64 groups x 63 x 63 words fit)
OFM_AW, 16, OFM BRAM address width (64 groups x 31 x 31 words fit)

Ports:
PCLK  in  1  clock
PRESET  in  1  synchronous active-high reset
pool_start  in  1  start register level from APB bank
flen  in  6  input map side length
in_channel  in  9  channel count
pool_done  out  1  completion flag
clk_counter  out  32  busy-cycle count of the last run
busy  out  1  high LOAD..DONE inclusive
ifm_en  out  1  IFM read enable
ifm_addr  out  IFM_AW  IFM read address
ifm_rdata  in  32  IFM data, valid 1 cycle after ifm_en
ofm_we  out  1  OFM write strobe
ofm_addr  out  OFM_AW  OFM write address
ofm_wdata  out  32  pooled word

Behaviour:
- Reset: state=IDLE. Outputs pool_done, busy, ifm_en, ofm_we = 0. clk_counter, ifm_addr, ofm_addr, ofm_wdata = 0. Previous-start register = 0. Reset mid-run aborts with no further BRAM accesses.
- Start = rising edge of pool_start (current 1, registered previous 0), accepted only in IDLE. Edge cycle clears clk_counter and pool_done. Edges while busy are ignored.
- States: IDLE -> LOAD -> (RD0 RD1 RD2 RD3 DRAIN WR) x N -> DONE -> IDLE.
- LOAD (1 cycle): latch flen and in_channel.
  - F = flen>>1 (odd flen drops the last row and column).
  - G = ceil(in_channel/4).
  - N = G*F*F.
  - If N==0 (flen<2 or in_channel==0): go to DONE.
- Output order: group g outer, then output row r, then output col c.
- IFM word address = g*flen*flen + row*flen + col.
- RDk (k=0..3): ifm_en=1 at (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1) respectively.
- Data for RDk is captured in the following cycle.
  - Capture from RD0 loads the max register.
  - Captures from RD1..RD3 update each byte lane i (channel 4g+i) independently as signed int8 max.
- DRAIN: captures RD3 data.
- WR: ofm_we=1, ofm_addr = g*F*F + r*F + c, ofm_wdata = max register. Then advance c, r, g; after the last window go to DONE.
- Lanes beyond in_channel in the last group are computed and written as-is.
- DONE (1 cycle): sets pool_done=1. pool_done holds until the next accepted start or reset.
- clk_counter increments each busy cycle, saturating at 32'hFFFFFFFF. Holds after DONE, so a run totals 6N+2 cycles.
- ifm_en and ofm_we are never high in the same cycle. ifm_addr and ofm_addr hold their last value when not strobed.

Optional Feature:
POOL_RELU_EN
- Defined: in WR, each byte lane of ofm_wdata with bit7=1 is replaced by 8'h00 (fused ReLU).
- Undefined: ofm_wdata equals the raw signed max.
- Timing and cycle counts are identical either way.

Test Plan:
- flen=4, in_channel=4, IFM words 0..15 with byte0 = address value (lanes 1-3 = 0) -> 4 writes, ofm_addr 0..3, ofm_wdata 5,7,13,15 in lane0. pool_done=1, clk_counter=26.
- flen=2, in_channel=4, lane0 values 8'h80, 8'hFF, 8'h01, 8'h7F -> single write with lane0 = 8'h7F. Lanes holding only negatives (e.g. all 8'hF0) -> 8'hF0, or 8'h00 with POOL_RELU_EN.
- flen=5, in_channel=8 -> F=2, G=2, N=8. Group1 first read ifm_addr=25, ofm_addr 4..7, clk_counter=50.
- flen=1 or in_channel=0 -> no ifm_en/ofm_we. pool_done after 2 busy cycles, clk_counter=2.
- Hold pool_start=1 through done, toggle 0->1 mid-run -> no restart. Fresh 0->1 after DONE clears pool_done and clk_counter in the edge cycle and reruns.
- PRESET asserted in RD2 of window 1 -> next cycle IDLE, all outputs 0, no ofm_we. Following start edge runs normally from ofm_addr 0.
